// File: rtl/adder_result_checker.sv
// Response-side checker for an adder DUT: delays the operands by the DUT
// latency, compares the DUT result with the golden a+b+cin, keeps saturating
// pass/fail counters and captures the first mismatching vector.
//
// Ports
//   clock, rst_n          rising-edge clock, synchronous active-low reset
//   start / stop / clear  control pulses (IDLE->RUN, RUN->DRAIN, flush to IDLE)
//   in_valid, in_a, in_b, in_cin   operands entering the delay pipe (RUN only)
//   dut_sum, dut_cout     DUT result, valid LATENCY cycles after its operands
//   busy, done            RUN/DRAIN indication, 1-cycle pulse on DRAIN->IDLE
//   chk_valid, chk_pass   registered result of the previous cycle's compare
//   pass_count, fail_count saturating compare counters
//   err_flag, err_a, err_b, err_cin, err_sum, err_cout  first mismatch capture
module adder_result_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic             err_cin,
  output logic [WIDTH-1:0] err_sum,
  output logic             err_cout
);

  localparam int unsigned DCNT_W     = 4;
  localparam int unsigned DRAIN_LAST = (LATENCY == 0) ? 0 : LATENCY - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } vec_t;

  state_t              state, state_next;
  logic [DCNT_W-1:0]   drain_cnt;
  vec_t                in_vec, exit_vec;
  logic                accept, flush, exit_valid, cmp_en, match;
  logic [WIDTH:0]      expected;

  assign in_vec = {in_a, in_b, in_cin};
  assign accept = in_valid && (state == RUN);
  // Entries are discarded on clear and whenever the checker sits in (or enters) HALT.
  assign flush  = clear || (state_next == HALT);

  // Operand delay pipe matching the DUT latency
  if (LATENCY == 0) begin : g_nopipe
    assign exit_valid = accept;
    assign exit_vec   = in_vec;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld;
    vec_t               stage [LATENCY];

    always_ff @(posedge clock) begin
      if (!rst_n || flush) begin
        vld <= '0;
      end else begin
        vld[0] <= accept;
        for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clock) begin
      stage[0] <= in_vec;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end

    assign exit_valid = vld[LATENCY-1];
    assign exit_vec   = stage[LATENCY-1];
  end

  // Golden compare; an unknown DUT value falls into the else path and fails
  assign expected = {1'b0, exit_vec.a} + {1'b0, exit_vec.b} + (WIDTH+1)'(exit_vec.cin);
  assign cmp_en   = exit_valid && ((state == RUN) || (state == DRAIN));

  always_comb begin
    match = 1'b0;
    if ({dut_cout, dut_sum} == expected) match = 1'b1;
  end

  // State register and drain-cycle counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= ((state == DRAIN) && (state_next == DRAIN)) ? drain_cnt + DCNT_W'(1) : '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN: begin
          if (STOP_ON_ERR && cmp_en && !match) state_next = HALT;
          else if (stop)                       state_next = DRAIN;
        end
        DRAIN:   if (drain_cnt == DCNT_W'(DRAIN_LAST)) state_next = IDLE;
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered status, counters and first-mismatch capture
  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      err_flag   <= 1'b0;
      err_a      <= '0;
      err_b      <= '0;
      err_cin    <= 1'b0;
      err_sum    <= '0;
      err_cout   <= 1'b0;
    end else begin
      busy      <= (state_next == RUN) || (state_next == DRAIN);
      done      <= (state == DRAIN) && (state_next == IDLE);
      chk_valid <= cmp_en;
      chk_pass  <= cmp_en && match;
      if (cmp_en) begin
        if (match) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
        end else begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_a    <= exit_vec.a;
            err_b    <= exit_vec.b;
            err_cin  <= exit_vec.cin;
            err_sum  <= dut_sum;
            err_cout <= dut_cout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker. Three instances share the stimulus:
// u_a LATENCY=0/STOP_ON_ERR=1, u_b LATENCY=2/STOP_ON_ERR=0/CNT_W=4,
// u_c LATENCY=3/STOP_ON_ERR=0. A behavioural adder delays the golden result
// per instance to act as the DUT; u_a can be corrupted with an XOR mask.
module tb_adder_result_checker;

  logic        clock = 1'b0;
  logic        rst_n, start, stop, clear, in_valid, in_cin;
  logic [31:0] in_a, in_b;
  logic [32:0] mask_a;
  logic [32:0] gold_now, res_a, res_b, res_c;
  logic [32:0] hist [0:7];

  logic        busy_a, done_a, cv_a, cp_a, ef_a, ecin_a, ecout_a;
  logic [15:0] pc_a, fc_a;
  logic [31:0] ea_a, eb_a, es_a;
  logic        busy_b, done_b, cv_b, cp_b, ef_b, ecin_b, ecout_b;
  logic [3:0]  pc_b, fc_b;
  logic [31:0] ea_b, eb_b, es_b;
  logic        busy_c, done_c, cv_c, cp_c, ef_c, ecin_c, ecout_c;
  logic [15:0] pc_c, fc_c;
  logic [31:0] ea_c, eb_c, es_c;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  // Behavioural DUT: golden sum, delayed per instance latency
  assign gold_now = {1'b0, in_a} + {1'b0, in_b} + {32'd0, in_cin};
  assign res_a    = gold_now ^ mask_a;
  assign res_b    = hist[1];
  assign res_c    = hist[2];

  always_ff @(posedge clock) begin
    hist[0] <= gold_now;
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end

  adder_result_checker #(.WIDTH(32), .LATENCY(0), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_a (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(res_a[31:0]), .dut_cout(res_a[32]),
    .busy(busy_a), .done(done_a), .chk_valid(cv_a), .chk_pass(cp_a),
    .pass_count(pc_a), .fail_count(fc_a), .err_flag(ef_a),
    .err_a(ea_a), .err_b(eb_a), .err_cin(ecin_a), .err_sum(es_a), .err_cout(ecout_a));

  adder_result_checker #(.WIDTH(32), .LATENCY(2), .CNT_W(4), .STOP_ON_ERR(1'b0)) u_b (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(res_b[31:0]), .dut_cout(res_b[32]),
    .busy(busy_b), .done(done_b), .chk_valid(cv_b), .chk_pass(cp_b),
    .pass_count(pc_b), .fail_count(fc_b), .err_flag(ef_b),
    .err_a(ea_b), .err_b(eb_b), .err_cin(ecin_b), .err_sum(es_b), .err_cout(ecout_b));

  adder_result_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_c (
    .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(res_c[31:0]), .dut_cout(res_c[32]),
    .busy(busy_c), .done(done_c), .chk_valid(cv_c), .chk_pass(cp_c),
    .pass_count(pc_c), .fail_count(fc_c), .err_flag(ef_c),
    .err_a(ea_c), .err_b(eb_c), .err_cin(ecin_c), .err_sum(es_c), .err_cout(ecout_c));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic put_rand();
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'($urandom_range(0, 1));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [32:0] mask;
    logic        exp_pass;
    logic [15:0] exp_pc;
    logic [15:0] exp_fc;
    logic        exp_err;
  } row_t;

  row_t rows [5];

  initial begin
    int n_cv, n_bad, first, n_done, d_step, a_step;

    rows[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h0,       1'b1, 16'd1, 16'd0, 1'b0};
    rows[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0,       1'b1, 16'd2, 16'd0, 1'b0};
    rows[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0,       1'b1, 16'd3, 16'd0, 1'b0};
    rows[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h0,       1'b1, 16'd4, 16'd0, 1'b0};
    rows[4] = '{32'h1234_5678, 32'h0000_FFFF, 1'b1, 33'h0000000F, 1'b0, 16'd4, 16'd1, 1'b1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; mask_a = '0;
    step(); step();
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_cv",   64'(cv_a | cv_b | cv_c), 64'd0);
    check("reset_cnt",  64'(pc_a | fc_a | pc_c | fc_c), 64'd0);
    check("reset_err",  64'(ef_a | ef_b | ef_c), 64'd0);
    rst_n = 1'b1;

    // Latency 0, stop on error: table of vectors, the last one corrupted
    start = 1'b1; step(); start = 1'b0;
    check("t1_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = rows[i].a; in_b = rows[i].b; in_cin = rows[i].cin;
      mask_a = rows[i].mask;
      step();
      in_valid = 1'b0; mask_a = '0;
      check($sformatf("t1_cv_%0d", i),   64'(cv_a), 64'd1);
      check($sformatf("t1_pass_%0d", i), 64'(cp_a), 64'(rows[i].exp_pass));
      check($sformatf("t1_pc_%0d", i),   64'(pc_a), 64'(rows[i].exp_pc));
      check($sformatf("t1_fc_%0d", i),   64'(fc_a), 64'(rows[i].exp_fc));
      check($sformatf("t1_ef_%0d", i),   64'(ef_a), 64'(rows[i].exp_err));
    end
    check("t2_err_a",    64'(ea_a),    64'h1234_5678);
    check("t2_err_b",    64'(eb_a),    64'h0000_FFFF);
    check("t2_err_cin",  64'(ecin_a),  64'd1);
    check("t2_err_sum",  64'(es_a),    64'h1235_5677);
    check("t2_err_cout", 64'(ecout_a), 64'd0);
    check("t2_halt_busy", 64'(busy_a), 64'd0);
    // HALT: a further (mismatching) valid is ignored
    in_valid = 1'b1; in_a = rows[4].a; in_b = rows[4].b; in_cin = 1'b1; mask_a = 33'h1;
    step();
    in_valid = 1'b0; mask_a = '0;
    check("t2_halt_cv", 64'(cv_a), 64'd0);
    check("t2_halt_fc", 64'(fc_a), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check("t2_clr_cnt", 64'(pc_a | fc_a), 64'd0);
    check("t2_clr_err", 64'({ef_a, ea_a}), 64'd0);

    // Latency 2: 10 back-to-back vectors, then 10 more to saturate CNT_W=4
    start = 1'b1; step(); start = 1'b0;
    n_cv = 0; n_bad = 0; first = 0;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 10) put_rand(); else in_valid = 1'b0;
      step();
      if (cv_b) begin
        n_cv++;
        if (!cp_b) n_bad++;
        if (first == 0) first = k;
      end
    end
    check("t3_cv_count", 64'(n_cv), 64'd10);
    check("t3_bad",      64'(n_bad), 64'd0);
    check("t3_first",    64'(first), 64'd3);
    check("t3_pc",       64'(pc_b), 64'd10);
    check("t3_fc",       64'(fc_b), 64'd0);
    n_cv = 0;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 10) put_rand(); else in_valid = 1'b0;
      step();
      if (cv_b) n_cv++;
    end
    check("t4_cv_count", 64'(n_cv), 64'd10);
    check("t4_pc_sat",   64'(pc_b), 64'hF);
    check("t4_fc",       64'(fc_b), 64'd0);
    clear = 1'b1; step(); clear = 1'b0;

    // Latency 3: stop together with the third vector, then drain
    start = 1'b1; step(); start = 1'b0;
    put_rand(); step();
    put_rand(); step();
    put_rand(); stop = 1'b1; step(); stop = 1'b0; in_valid = 1'b0;
    check("t5_drain_busy", 64'(busy_c), 64'd1);
    n_cv = 0; n_done = 0; d_step = 0; a_step = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (cv_c) n_cv++;
      if (done_c) begin n_done++; d_step = k; end
      if (done_a) a_step = k;
    end
    check("t5_cv_count", 64'(n_cv), 64'd3);
    check("t5_done_cnt", 64'(n_done), 64'd1);
    check("t5_done_at",  64'(d_step), 64'd3);
    check("t5_l0_done",  64'(a_step), 64'd1);
    check("t5_busy",     64'(busy_c), 64'd0);
    check("t5_pc",       64'(pc_c), 64'd3);

    // Clear with two entries in flight
    start = 1'b1; step(); start = 1'b0;
    put_rand(); step();
    put_rand(); step();
    in_valid = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    check("t6_clr_busy", 64'(busy_c), 64'd0);
    check("t6_clr_pc",   64'(pc_c), 64'd0);
    n_cv = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (cv_c) n_cv++;
    end
    check("t6_clr_cv", 64'(n_cv), 64'd0);

    // Reset with entries in flight
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin put_rand(); step(); end
    in_valid = 1'b0;
    check("t6_pre_rst_pc", 64'(pc_c), 64'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t6_rst_busy", 64'(busy_c), 64'd0);
    check("t6_rst_pc",   64'(pc_c), 64'd0);
    n_cv = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (cv_c) n_cv++;
    end
    check("t6_rst_cv", 64'(n_cv), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
